// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature generator and the quadrature decoder:
// FSM states and the per-direction transition tables.
package quad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    HOLD,
    DONE
  } state_t;

  localparam logic [1:0] REST = 2'b00;

  // Transition i of a detent is held in bits [7-2i -: 2]; {b,a} order.
  localparam logic [7:0] SEQ_DIR1 = {2'b10, 2'b11, 2'b01, 2'b00};
  localparam logic [7:0] SEQ_DIR0 = {2'b01, 2'b11, 2'b10, 2'b00};

  function automatic logic [1:0] seq_at(input logic dir, input logic [1:0] idx);
    logic [7:0] tbl;
    tbl = dir ? SEQ_DIR1 : SEQ_DIR0;
    return tbl[7 - 2 * int'(idx) -: 2];
  endfunction

endpackage

// File: rtl/quad_phase_timer.sv
// Loadable down-counter shared by the BOUNCE and HOLD intervals; tc flags
// the last cycle of an interval, odd exposes the count parity.
module quad_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc,
  output logic         odd
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc  = (count == '0);
  assign odd = count[0];

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature transmitter: turns detent step commands into registered A/B
// waveforms, optionally with contact bounce on every edge.
module quad_encoder_gen
  import quad_pkg::*;
#(
  parameter int PHASE_CYCLES  = 4,
  parameter int BOUNCE_PULSES = 0,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_valid,
  input  logic             step_dir,
  input  logic [CNT_W-1:0] step_count,
  output logic             step_ready,
  output logic             busy,
  output logic             step_done,
  output logic             rot_a,
  output logic             rot_b
);

  localparam int SPAN = (PHASE_CYCLES > 2 * BOUNCE_PULSES) ? PHASE_CYCLES : 2 * BOUNCE_PULSES;
  localparam int TW   = $clog2(SPAN) + 1;
  localparam logic [TW-1:0] HOLD_LAST   = TW'(PHASE_CYCLES - 1);
  localparam logic [TW-1:0] BOUNCE_LAST = (BOUNCE_PULSES > 0) ? TW'(2 * BOUNCE_PULSES - 1) : '0;

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       lines_q, lines_d;

  logic             tmr_load, tmr_tc, tmr_odd;
  logic [TW-1:0]    tmr_val;
  logic             start_tr, start_dir;
  logic [1:0]       start_idx;

  quad_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc),
    .odd      (tmr_odd)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    lines_d   = REST;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    start_tr  = 1'b0;
    start_dir = dir_q;
    start_idx = 2'd0;

    case (state_q)
      IDLE: begin
        if (step_valid) begin
          dir_d   = step_dir;
          cnt_d   = step_count;
          phase_d = 2'd0;
          if (step_count == '0) begin
            state_d = DONE;
          end else begin
            start_tr  = 1'b1;
            start_dir = step_dir;
          end
        end
      end

      BOUNCE: begin
        if (tmr_tc) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LAST;
          lines_d  = seq_at(dir_q, phase_q);
        end else begin
          // Next bounce index is odd exactly when the current count is odd.
          lines_d = tmr_odd ? seq_at(dir_q, phase_q - 2'd1) : seq_at(dir_q, phase_q);
        end
      end

      HOLD: begin
        lines_d = seq_at(dir_q, phase_q);
        if (tmr_tc) begin
          phase_d = phase_q + 2'd1;
          if (phase_q != 2'd3) begin
            start_tr  = 1'b1;
            start_idx = phase_q + 2'd1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q != CNT_W'(1)) begin
              start_tr = 1'b1;
            end else begin
              state_d = DONE;
              lines_d = REST;
            end
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Every transition opens with its new value: first bounce half or settled.
    if (start_tr) begin
      tmr_load = 1'b1;
      lines_d  = seq_at(start_dir, start_idx);
      if (BOUNCE_PULSES > 0) begin
        state_d = BOUNCE;
        tmr_val = BOUNCE_LAST;
      end else begin
        state_d = HOLD;
        tmr_val = HOLD_LAST;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 2'd0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      lines_q <= REST;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      lines_q <= lines_d;
    end
  end

  assign step_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign step_done  = (state_q == DONE);
  assign rot_b      = lines_q[1];
  assign rot_a      = lines_q[0];

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: a clean-edge and a bouncing instance checked
// cycle by cycle against a waveform model built from the detent rules.
module tb_quad_encoder_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] valid;
  logic       dir;
  logic [7:0] cnt;
  logic [1:0] rdy, bsy, dn, ra, rb;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] seq1 [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] seq0 [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  typedef struct {
    logic [1:0] lines;
    logic       done;
  } samp_t;
  samp_t exp_q[$];

  always #5 clk = ~clk;

  quad_encoder_gen #(.PHASE_CYCLES(4), .BOUNCE_PULSES(0), .CNT_W(8)) u_clean (
    .clk(clk), .rst(rst), .step_valid(valid[0]), .step_dir(dir), .step_count(cnt),
    .step_ready(rdy[0]), .busy(bsy[0]), .step_done(dn[0]), .rot_a(ra[0]), .rot_b(rb[0])
  );

  quad_encoder_gen #(.PHASE_CYCLES(3), .BOUNCE_PULSES(2), .CNT_W(8)) u_bounce (
    .clk(clk), .rst(rst), .step_valid(valid[1]), .step_dir(dir), .step_count(cnt),
    .step_ready(rdy[1]), .busy(bsy[1]), .step_done(dn[1]), .rot_a(ra[1]), .rot_b(rb[1])
  );

  function automatic int p_of(input int u);
    return (u == 0) ? 4 : 3;
  endfunction

  function automatic int bp_of(input int u);
    return (u == 0) ? 0 : 2;
  endfunction

  // {busy, ready, done, b, a}
  function automatic logic [4:0] obs(input int u);
    return {bsy[u], rdy[u], dn[u], rb[u], ra[u]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  // Per-cycle expectation for a whole command, starting the cycle after acceptance.
  task automatic build(input int u, input bit d, input int c);
    logic [1:0] prev, nw;
    samp_t s;
    exp_q.delete();
    prev = 2'b00;
    for (int det = 0; det < c; det++) begin
      for (int i = 0; i < 4; i++) begin
        nw = d ? seq1[i] : seq0[i];
        for (int k = 0; k < 2 * bp_of(u); k++) begin
          s.lines = (k % 2 == 0) ? nw : prev;
          s.done  = 1'b0;
          exp_q.push_back(s);
        end
        for (int p = 0; p < p_of(u); p++) begin
          s.lines = nw;
          s.done  = 1'b0;
          exp_q.push_back(s);
        end
        prev = nw;
      end
    end
    s.lines = 2'b00;
    s.done  = 1'b1;
    exp_q.push_back(s);
  endtask

  task automatic issue(input int u, input bit d, input int c);
    @(negedge clk);
    check($sformatf("u%0d ready_before_issue", u), rdy[u], 1);
    valid[u] = 1'b1;
    dir      = d;
    cnt      = 8'(c);
    @(posedge clk);
  endtask

  // Checks a command already accepted; nv/nd/nc are driven right after
  // acceptance (a chained command, or ignored garbage when nv=0).
  task automatic wave(input int u, input bit d, input int c,
                      input bit nv, input bit nd, input int nc);
    build(u, d, c);
    foreach (exp_q[i]) begin
      @(negedge clk);
      check($sformatf("u%0d d%0d c%0d cyc%0d", u, d, c, i + 1), obs(u),
            {1'b1, 1'b0, exp_q[i].done, exp_q[i].lines});
      if (i == 0) begin
        valid[u] = nv;
        dir      = nd;
        cnt      = 8'(nc);
      end
    end
    @(negedge clk);
    check($sformatf("u%0d d%0d c%0d idle_after", u, d, c), obs(u), 5'b01000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int u, c, nc;
    bit d, nv, nd;
    valid = 2'b00;
    dir   = 1'b0;
    cnt   = 8'd0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    check("reset u0", obs(0), 5'b01000);
    check("reset u1", obs(1), 5'b01000);
    rst = 1'b0;

    // Directed cases
    issue(0, 1, 1);  wave(0, 1, 1, 0, 1'($urandom), 8'($urandom));
    issue(0, 0, 3);  wave(0, 0, 3, 0, 1'($urandom), 8'($urandom));
    issue(1, 1, 1);  wave(1, 1, 1, 0, 1'($urandom), 8'($urandom));
    issue(1, 0, 2);  wave(1, 0, 2, 0, 1'($urandom), 8'($urandom));
    issue(0, 1, 2);  wave(0, 1, 2, 1, 0, 1);  wave(0, 0, 1, 0, 1, 5);
    issue(1, 0, 0);  wave(1, 0, 0, 1, 1, 0);  wave(1, 1, 0, 0, 0, 7);
    issue(0, 1, 0);  wave(0, 1, 0, 1, 1, 1);  wave(0, 1, 1, 0, 0, 3);

    // Reset while the lines sit at 11 mid-detent
    issue(0, 1, 2);
    build(0, 1, 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("pre_rst cyc%0d", i + 1), obs(0), {3'b100, exp_q[i].lines});
      if (i == 0) valid[0] = 1'b0;
    end
    #2 rst = 1'b1;
    #1 check("rst_async u0", obs(0), 5'b01000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_rst cyc%0d", i), obs(0), 5'b01000);
    end
    issue(0, 0, 1);  wave(0, 0, 1, 0, 1'($urandom), 8'($urandom));

    // Randomized commands, some chained back-to-back
    u = $urandom_range(0, 1);
    d = 1'($urandom);
    c = $urandom_range(0, 3);
    issue(u, d, c);
    for (int n = 0; n < 24; n++) begin
      nv = ($urandom_range(0, 1) == 1) && (n < 23);
      nd = 1'($urandom);
      nc = $urandom_range(0, 3);
      wave(u, d, c, nv, nd, nc);
      if (nv) begin
        d = nd;
        c = nc;
      end else if (n < 23) begin
        u = $urandom_range(0, 1);
        d = 1'($urandom);
        c = $urandom_range(0, 3);
        issue(u, d, c);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
